latch_write_sequencer: RTL and testbench

Controller that shares one WIDTH-bit bank of level-sensitive D latches between two requesters. It arbitrates round-robin and registers the winner's data onto the latch D bus. It then sequences the latch enable through setup, enable and hold windows, reads the latch Q back and acknowledges. It sits between the requesting logic and the `latch_bank` instance, which is built from the team's D latch cells. All latch timing in the design is owned here.

---
 rtl/latch_ctrl_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 24 ++
 rtl/latch_write_sequencer.sv | 142 ++++++++++++++
 tb/tb_latch_write_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/latch_ctrl_pkg.sv
// Shared definitions for the latch write sequencer: state encoding and
// counter sizing helper.
package latch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ENABLE,
        ST_HOLD,
        ST_CHECK
    } state_e;

    // Counter holds at most max(window)-1, so clog2(max) bits, never below 1.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: pointer selects the winner on a tie and
// moves to the loser whenever a grant is taken.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       ptr_next
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        ptr_next = ptr;
        if (advance && (req != 2'b00))
            ptr_next = gnt[0];
    end

endmodule

// File: rtl/latch_write_sequencer.sv
// Arbitrates two writers onto a shared D-latch bank and sequences the latch
// enable through setup / enable / hold windows, then checks the readback.
module latch_write_sequencer
    import latch_ctrl_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int SETUP_CYCLES = 1,
    parameter int EN_CYCLES    = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       REQ,
    input  logic [WIDTH-1:0] DATA0,
    input  logic [WIDTH-1:0] DATA1,
    output logic [1:0]       GNT,
    output logic             DONE,
    output logic             BUSY,
    output logic             ERR,
    output logic [WIDTH-1:0] LD,
    output logic             LC,
    input  logic [WIDTH-1:0] Q
);

    localparam int CNT_W = cnt_width(SETUP_CYCLES, EN_CYCLES, HOLD_CYCLES);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ptr_q, ptr_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] ld_q, ld_d;
    logic             lc_q, lc_d;

    logic [1:0] arb_gnt;
    logic       arb_ptr_next;
    logic       arb_adv;

    assign arb_adv = (state_q == ST_IDLE) && (REQ != 2'b00);

    rr_arbiter2 u_arb (
        .req      (REQ),
        .ptr      (ptr_q),
        .advance  (arb_adv),
        .gnt      (arb_gnt),
        .ptr_next (arb_ptr_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        ld_d    = ld_q;
        lc_d    = lc_q;
        case (state_q)
            ST_IDLE: begin
                // LD is loaded only here, so it is frozen for the whole latch window.
                if (arb_adv) begin
                    gnt_d   = arb_gnt;
                    ptr_d   = arb_ptr_next;
                    ld_d    = arb_gnt[1] ? DATA1 : DATA0;
                    cnt_d   = SETUP_LD;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_ENABLE;
                    cnt_d   = EN_LD;
                    lc_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ENABLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                    lc_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                    done_d  = 1'b1;
                    if (Q != ld_q)
                        err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
            gnt_q   <= 2'b00;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            ld_q    <= '0;
            lc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            ld_q    <= ld_d;
            lc_q    <= lc_d;
        end
    end

    assign GNT  = gnt_q;
    assign DONE = done_q;
    assign BUSY = busy_q;
    assign ERR  = err_q;
    assign LD   = ld_q;
    assign LC   = lc_q;

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Bench: default-timing and stretched-timing sequencers driven side by side,
// each with its own latch bank, checked against a time-since-grant model.
module tb_latch_write_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic       q_force = 1'b0;
    logic       chk_en = 1'b0;

    logic [1:0][1:0] gnt_o;
    logic [1:0]      done_o, busy_o, err_o, lc_o;
    logic [1:0][7:0] ld_o;
    logic [7:0]      lat_a, lat_b, q_a, q_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Latch banks: transparent while C is high.
    always_latch if (lc_o[0]) lat_a <= ld_o[0];
    always_latch if (lc_o[1]) lat_b <= ld_o[1];
    assign q_a = q_force ? 8'h00 : lat_a;
    assign q_b = q_force ? 8'h00 : lat_b;

    latch_write_sequencer #(.WIDTH(8), .SETUP_CYCLES(1), .EN_CYCLES(2), .HOLD_CYCLES(1)) u_a (
        .CLK(clk), .RST(rst), .REQ(req), .DATA0(d0), .DATA1(d1),
        .GNT(gnt_o[0]), .DONE(done_o[0]), .BUSY(busy_o[0]), .ERR(err_o[0]),
        .LD(ld_o[0]), .LC(lc_o[0]), .Q(q_a)
    );

    latch_write_sequencer #(.WIDTH(8), .SETUP_CYCLES(2), .EN_CYCLES(3), .HOLD_CYCLES(2)) u_b (
        .CLK(clk), .RST(rst), .REQ(req), .DATA0(d0), .DATA1(d1),
        .GNT(gnt_o[1]), .DONE(done_o[1]), .BUSY(busy_o[1]), .ERR(err_o[1]),
        .LD(ld_o[1]), .LC(lc_o[1]), .Q(q_b)
    );

    // Model: a transaction is just "t cycles since the grant edge".
    int         S_[2] = '{1, 2};
    int         E_[2] = '{2, 3};
    int         H_[2] = '{1, 2};
    logic       m_busy[2] = '{1'b0, 1'b0};
    int         m_t[2]    = '{0, 0};
    logic       m_ptr[2]  = '{1'b0, 1'b0};
    logic [1:0] m_win[2]  = '{2'b00, 2'b00};
    logic [7:0] m_ld[2]   = '{8'h00, 8'h00};
    logic [7:0] m_lat[2]  = '{8'h00, 8'h00};
    logic       m_err[2]  = '{1'b0, 1'b0};

    function automatic logic exp_lc(input int i);
        return m_busy[i] && (m_t[i] >= S_[i]) && (m_t[i] < S_[i] + E_[i]);
    endfunction

    function automatic logic exp_done(input int i);
        return m_busy[i] && (m_t[i] == S_[i] + E_[i] + H_[i]);
    endfunction

    task automatic model_step(input int i);
        logic [7:0] qn;
        int last;
        int w;
        qn   = q_force ? 8'h00 : m_lat[i];
        last = S_[i] + E_[i] + H_[i];
        if (rst) begin
            m_busy[i] = 1'b0; m_t[i] = 0; m_ptr[i] = 1'b0;
            m_win[i] = 2'b00; m_ld[i] = 8'h00; m_err[i] = 1'b0;
        end else if (m_busy[i]) begin
            if (m_t[i] == last) begin
                m_busy[i] = 1'b0;
                m_win[i]  = 2'b00;
            end else begin
                m_t[i] = m_t[i] + 1;
                if (m_t[i] == last && qn != m_ld[i]) m_err[i] = 1'b1;
            end
        end else if (req != 2'b00) begin
            if (req == 2'b11) w = m_ptr[i] ? 1 : 0;
            else              w = req[1] ? 1 : 0;
            m_win[i]  = (w == 1) ? 2'b10 : 2'b01;
            m_ptr[i]  = (w == 0);
            m_ld[i]   = (w == 1) ? d1 : d0;
            m_busy[i] = 1'b1;
            m_t[i]    = 0;
        end
        if (exp_lc(i)) m_lat[i] = m_ld[i];
    endtask

    initial forever begin
        @(posedge clk);
        model_step(0);
        model_step(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("gnt%0d", i),  gnt_o[i],  m_win[i]);
                chk($sformatf("done%0d", i), done_o[i], exp_done(i));
                chk($sformatf("busy%0d", i), busy_o[i], m_busy[i]);
                chk($sformatf("err%0d", i),  err_o[i],  m_err[i]);
                chk($sformatf("ld%0d", i),   ld_o[i],   m_ld[i]);
                chk($sformatf("lc%0d", i),   lc_o[i],   exp_lc(i));
                if (exp_done(i))
                    chk($sformatf("q%0d", i), (i == 0) ? q_a : q_b, q_force ? 8'h00 : m_lat[i]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 2'b00; q_force = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int lc_cnt_b;
        int done_b;
        tick(2);
        chk_en = 1'b1;
        chk("rst_gnt", gnt_o[0], 2'b00);
        chk("rst_busy", busy_o[0], 1'b0);
        chk("rst_lc", lc_o[0], 1'b0);

        // Single write from requester 0; also times the stretched instance.
        rst = 1'b0; req = 2'b01; d0 = 8'hA5; d1 = 8'h00;
        lc_cnt_b = 0; done_b = 0;
        for (int c = 1; c <= 10; c++) begin
            tick(1);
            if (c == 1) begin chk("t1_gnt", gnt_o[0], 2'b01); req = 2'b00; end
            if (c == 2 || c == 3) chk("t1_lc_hi", lc_o[0], 1'b1);
            if (c == 4) chk("t1_lc_lo", lc_o[0], 1'b0);
            if (c == 5) begin
                chk("t1_done", done_o[0], 1'b1);
                chk("t1_q", q_a, 8'hA5);
                chk("t1_err", err_o[0], 1'b0);
            end
            if (lc_o[1]) lc_cnt_b++;
            if (done_o[1] && done_b == 0) done_b = c;
        end
        chk("t6_lc_len", lc_cnt_b, 3);
        chk("t6_done_cyc", done_b, 8);

        // Both requesting: alternate 0,1,0 every 6 cycles.
        do_reset();
        req = 2'b11; d0 = 8'h11; d1 = 8'h22;
        for (int c = 1; c <= 18; c++) begin
            tick(1);
            if (c == 1)  chk("t2_g1", gnt_o[0], 2'b01);
            if (c == 7)  chk("t2_g2", gnt_o[0], 2'b10);
            if (c == 13) chk("t2_g3", gnt_o[0], 2'b01);
            if (c == 5)  chk("t2_q1", q_a, 8'h11);
            if (c == 11) chk("t2_q2", q_a, 8'h22);
            if (c == 17) chk("t2_q3", q_a, 8'h11);
        end
        req = 2'b00; tick(10);

        // DATA change during SETUP must not reach LD.
        do_reset();
        req = 2'b01; d0 = 8'h3C;
        for (int c = 1; c <= 9; c++) begin
            tick(1);
            if (c == 1) begin req = 2'b00; d0 = 8'hFF; end
            if (c == 3) chk("t3_ld", ld_o[0], 8'h3C);
            if (c == 5) chk("t3_q", q_a, 8'h3C);
        end

        // Forced bad readback sets sticky ERR.
        do_reset();
        q_force = 1'b1; req = 2'b01; d0 = 8'h5A;
        for (int c = 1; c <= 10; c++) begin
            tick(1);
            if (c == 1) req = 2'b00;
            if (c == 5) chk("t4_err_set", err_o[0], 1'b1);
            if (c == 9) q_force = 1'b0;
        end
        req = 2'b10; d1 = 8'h77;
        tick(1); req = 2'b00; tick(10);
        chk("t4_err_sticky", err_o[0], 1'b1);
        do_reset();
        tick(1);
        chk("t4_err_clr", err_o[0], 1'b0);

        // Reset during ENABLE, with REQ high on the reset edge.
        req = 2'b01; d0 = 8'h81;
        tick(1); req = 2'b00;
        tick(1);
        rst = 1'b1; req = 2'b11;
        tick(1);
        chk("t5_lc", lc_o[0], 1'b0);
        chk("t5_gnt", gnt_o[0], 2'b00);
        chk("t5_busy", busy_o[0], 1'b0);
        chk("t5_done", done_o[0], 1'b0);
        rst = 1'b0;
        tick(1);
        chk("t5_regrant", gnt_o[0], 2'b01);
        req = 2'b00; tick(12);

        // Random traffic, occasional resets and readback faults.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 99) == 0);
            req     = 2'($urandom_range(0, 3));
            d0      = 8'($urandom);
            d1      = 8'($urandom);
            q_force = ($urandom_range(0, 7) == 0);
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
